// File: rtl/pal_cfg_loader.sv
// Configuration sequencer for the PAL fabric: streams config bytes LSB-first onto the
// one-bit CFG chain, exactly CFG_LEN bits, then raises PAL_EN.
module pal_cfg_loader #(
    parameter int unsigned CFG_LEN = 300,
    parameter int unsigned CNT_W   = $clog2(CFG_LEN + 1)
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    output logic       CFG_OUT,
    output logic       CFG_SHIFT,
    output logic       PAL_EN,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StActive
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       buf_q, buf_d;
    // Bits in the buffer still to be emitted (0..8); final byte loads fewer than 8.
    logic [3:0]       buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic             done_q, done_d;
    logic             accept;

    assign CFG_SHIFT  = (state_q == StLoad) && (buf_cnt_q != 4'd0);
    assign CFG_OUT    = CFG_SHIFT & buf_q[0];
    assign DATA_READY = (state_q == StLoad) && !ABORT
                        && (32'(bits_left_q) > 32'(buf_cnt_q))
                        && (buf_cnt_q <= 4'd1);
    assign accept     = DATA_VALID & DATA_READY;
    assign BUSY       = (state_q == StLoad);
    assign PAL_EN     = (state_q == StActive);
    assign DONE       = done_q;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_cnt_d   = buf_cnt_q;
        bits_left_d = bits_left_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle, StActive: begin
                if (START) begin
                    state_d     = StLoad;
                    bits_left_d = CNT_W'(CFG_LEN);
                    buf_d       = 8'h00;
                    buf_cnt_d   = 4'd0;
                end
            end
            StLoad: begin
                if (CFG_SHIFT) begin
                    buf_d       = {1'b0, buf_q[7:1]};
                    buf_cnt_d   = buf_cnt_q - 4'd1;
                    bits_left_d = bits_left_q - CNT_W'(1);
                end
                // A new byte only keeps as many bits as the chain still needs.
                if (accept) begin
                    buf_d     = DATA_IN;
                    buf_cnt_d = (32'(bits_left_d) >= 32'd8) ? 4'd8 : 4'(bits_left_d);
                end
                if (CFG_SHIFT && (bits_left_q == CNT_W'(1))) begin
                    state_d = StActive;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ABORT) begin
            state_d     = StIdle;
            buf_d       = 8'h00;
            buf_cnt_d   = 4'd0;
            bits_left_d = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= StIdle;
            buf_q       <= 8'h00;
            buf_cnt_q   <= 4'd0;
            bits_left_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
            bits_left_q <= bits_left_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: a CFG_LEN=12 instance for timing/abort/reload and a
// default-length instance for the full 300-bit load.
module tb_pal_cfg_loader;

    logic       CLK = 1'b0;
    logic       RES, START, ABORT, DATA_VALID;
    logic [7:0] DATA_IN;
    logic       DATA_READY, CFG_OUT, CFG_SHIFT, PAL_EN, BUSY, DONE;

    logic       s_start, s_abort, s_valid;
    logic [7:0] s_data;
    logic       s_ready, s_out, s_shift, s_pal_en, s_busy, s_done;

    int errors = 0;
    int checks = 0;

    pal_cfg_loader #(.CFG_LEN(12)) dut (
        .CLK(CLK), .RES(RES), .START(START), .ABORT(ABORT), .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .CFG_OUT(CFG_OUT),
        .CFG_SHIFT(CFG_SHIFT), .PAL_EN(PAL_EN), .BUSY(BUSY), .DONE(DONE)
    );

    pal_cfg_loader dut300 (
        .CLK(CLK), .RES(RES), .START(s_start), .ABORT(s_abort), .DATA_IN(s_data),
        .DATA_VALID(s_valid), .DATA_READY(s_ready), .CFG_OUT(s_out),
        .CFG_SHIFT(s_shift), .PAL_EN(s_pal_en), .BUSY(s_busy), .DONE(s_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Entered at the first LOAD cycle; b0 accepted now, b1 back-to-back 8 cycles later.
    task automatic load2(input string t, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [11:0] pat);
        START = 1'b0; DATA_IN = b0; DATA_VALID = 1'b1; #1;
        chk({t, "_busy"}, BUSY, 1);
        chk({t, "_palen_low"}, PAL_EN, 0);
        chk({t, "_rdy0"}, DATA_READY, 1);
        chk({t, "_noshift0"}, CFG_SHIFT, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(); DATA_VALID = (i == 7); DATA_IN = b1; #1;
            chk($sformatf("%s_shift%0d", t, i), CFG_SHIFT, 1);
            chk($sformatf("%s_bit%0d", t, i), CFG_OUT, pat[i]);
            chk($sformatf("%s_rdy%0d", t, i), DATA_READY, (i == 7));
        end
        cyc(); DATA_VALID = 1'b0; #1;
        chk({t, "_palen"}, PAL_EN, 1);
        chk({t, "_done"}, DONE, 1);
        chk({t, "_notbusy"}, BUSY, 0);
        cyc(); #1;
        chk({t, "_done_pulse"}, DONE, 0);
        chk({t, "_palen_hold"}, PAL_EN, 1);
    endtask

    initial begin
        logic [7:0] a5;
        int nacc, nshift, ntail, ndone;
        logic tailbad, accepted39;

        RES = 1'b1; START = 1'b0; ABORT = 1'b0; DATA_VALID = 1'b0; DATA_IN = 8'h00;
        s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        a5 = 8'hA5;

        // T1: reset
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t1_out", {DATA_READY, CFG_OUT, CFG_SHIFT, PAL_EN, BUSY, DONE}, 0);
            chk("t1_out300", {s_ready, s_out, s_shift, s_pal_en, s_busy, s_done}, 0);
        end
        cyc(); RES = 1'b0; DATA_VALID = 1'b1; DATA_IN = 8'h55; #1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_idle_rdy", DATA_READY, 0);
            chk("t1_idle_busy", BUSY, 0);
            cyc(); #1;
        end
        DATA_VALID = 1'b0;

        // T2: back-to-back streaming
        cyc(); START = 1'b1; #1;
        chk("t2_idle", BUSY, 0);
        cyc();
        load2("t2", 8'hA5, 8'h03, 12'h3A5);

        cyc(); ABORT = 1'b1; #1;
        chk("abort_cycle_palen", PAL_EN, 1);
        cyc(); ABORT = 1'b0; #1;
        chk("abort_idle", {PAL_EN, BUSY, DONE}, 0);

        // T3: source stall between bytes
        cyc(); START = 1'b1; #1;
        cyc(); START = 1'b0; DATA_IN = 8'hA5; DATA_VALID = 1'b1; #1;
        chk("t3_rdy0", DATA_READY, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(); DATA_VALID = 1'b0; #1;
            chk("t3_shift_a", CFG_SHIFT, 1);
            chk($sformatf("t3_bit%0d", i), CFG_OUT, a5[i]);
        end
        for (int c = 10; c < 20; c++) begin
            cyc(); #1;
            chk($sformatf("t3_stall%0d", c), {CFG_SHIFT, CFG_OUT, DATA_READY, BUSY}, 4'b0011);
        end
        cyc(); DATA_VALID = 1'b1; DATA_IN = 8'h03; #1;
        chk("t3_c20", {CFG_SHIFT, DATA_READY}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cyc(); DATA_VALID = 1'b0; #1;
            chk("t3_shift_b", CFG_SHIFT, 1);
            chk($sformatf("t3_tail%0d", i), CFG_OUT, (i < 2));
        end
        cyc(); #1;
        chk("t3_palen", PAL_EN, 1);
        chk("t3_done", DONE, 1);

        // T5: reload from ACTIVE
        cyc(); START = 1'b1; #1;
        chk("t5_palen_before", PAL_EN, 1);
        cyc();
        load2("t5", 8'h5A, 8'h0C, 12'hC5A);

        // T4: abort; ready forced low in the abort cycle; abort mid-load
        cyc(); ABORT = 1'b1; #1;
        cyc(); ABORT = 1'b0; START = 1'b1; #1;
        cyc(); START = 1'b0; ABORT = 1'b1; DATA_VALID = 1'b1; DATA_IN = 8'h77; #1;
        chk("t4_rdy_abort", DATA_READY, 0);
        cyc(); ABORT = 1'b0; DATA_VALID = 1'b0; #1;
        chk("t4_idle_a", BUSY, 0);
        START = 1'b1;
        cyc(); START = 1'b0; DATA_VALID = 1'b1; DATA_IN = 8'hA5; #1;
        chk("t4_rdy0", DATA_READY, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); DATA_VALID = 1'b0; #1;
            chk("t4_shift", CFG_SHIFT, 1);
        end
        cyc(); ABORT = 1'b1; DATA_VALID = 1'b1; #1;
        cyc(); ABORT = 1'b0; DATA_VALID = 1'b0; #1;
        chk("t4_after_abort", {BUSY, PAL_EN, DONE, CFG_SHIFT}, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t4_no_done", {DONE, PAL_EN}, 0);
        end
        cyc(); START = 1'b1; #1;
        cyc();
        load2("t4", 8'hFF, 8'h0F, 12'hFFF);

        // T6: full-length chain on the default instance
        nacc = 0; nshift = 0; ntail = 0; ndone = 0; tailbad = 1'b0; accepted39 = 1'b0;
        cyc(); s_start = 1'b1; #1;
        cyc(); s_start = 1'b0;
        for (int c = 0; c < 320; c++) begin
            s_valid = 1'b1;
            s_data  = (nacc < 37) ? 8'(nacc * 13 + 7) : (nacc == 37) ? 8'hF0 : 8'hAA;
            #1;
            if (s_shift) begin
                nshift++;
                if (nacc == 38) begin
                    ntail++;
                    if (s_out) tailbad = 1'b1;
                end
            end
            if (s_done) ndone++;
            if (s_ready) begin
                if (nacc == 38) accepted39 = 1'b1;
                nacc++;
            end
            cyc();
        end
        s_valid = 1'b0; #1;
        chk("t6_bytes", nacc, 38);
        chk("t6_shifts", nshift, 300);
        chk("t6_tail_shifts", ntail, 4);
        chk("t6_tail_zero", tailbad, 0);
        chk("t6_byte39", accepted39, 0);
        chk("t6_done_count", ndone, 1);
        chk("t6_palen", s_pal_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
